sb_coalesce: RTL and testbench

Parametrised, coalescing store buffer between the LSU and the data cache. It holds retired stores as word-aligned entries with per-byte enables, merges stores to the same word, and forwards store data to younger loads at byte granularity. It drains entries oldest-first to the cache over a valid/ready port. It generalises the fixed 4-entry word/byte store buffer to arbitrary depth, byte/half/word sizes, partial-overlap detection and explicit flush.

---
 rtl/sb_coalesce_if.sv | 64 ++++++
 rtl/sb_coalesce.sv | 278 +++++++++++++++++++++++++++
 tb/tb_sb_coalesce.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sb_coalesce_if.sv
`default_nettype none
// ============================================================================
// Module      : sb_coalesce_if
// Description : Bundle of the store, load-forwarding, drain and status signals
//               of the coalescing store buffer.
//               master : LSU / cache side (drives requests, drain_ready, flush)
//               slave  : store buffer side (drives ready, lookup results,
//                        drain entry and occupancy status)
// Revision    : 1.0 - initial release
// ============================================================================
interface sb_coalesce_if #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 8
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    // store port
    logic               st_valid;
    logic               st_ready;
    logic [ADDR_W-1:0]  st_addr;
    logic [31:0]        st_data;
    logic [1:0]         st_size;
    logic               st_misalign;
    // load forwarding lookup
    logic               ld_valid;
    logic [ADDR_W-1:0]  ld_addr;
    logic [1:0]         ld_size;
    logic               ld_hit;
    logic               ld_partial;
    logic [31:0]        ld_data;
    // drain port towards the data cache
    logic               drain_valid;
    logic               drain_ready;
    logic [ADDR_W-1:0]  drain_addr;
    logic [31:0]        drain_data;
    logic [3:0]         drain_be;
    // flush and occupancy
    logic               flush;
    logic               flush_busy;
    logic               full;
    logic               empty;
    logic [c_CNT_W-1:0] count;

    modport master (
        output st_valid, st_addr, st_data, st_size,
        output ld_valid, ld_addr, ld_size,
        output drain_ready, flush,
        input  st_ready, st_misalign,
        input  ld_hit, ld_partial, ld_data,
        input  drain_valid, drain_addr, drain_data, drain_be,
        input  flush_busy, full, empty, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_size,
        input  ld_valid, ld_addr, ld_size,
        input  drain_ready, flush,
        output st_ready, st_misalign,
        output ld_hit, ld_partial, ld_data,
        output drain_valid, drain_addr, drain_data, drain_be,
        output flush_busy, full, empty, count
    );
endinterface
`default_nettype wire

// File: rtl/sb_coalesce.sv
`default_nettype none
// ============================================================================
// Module      : sb_coalesce
// Description : Coalescing store buffer between the LSU and the data cache.
//               Retired stores are held as word-aligned entries with per-byte
//               enables in a circular FIFO. Stores to a buffered word merge
//               into the youngest matching entry, loads are forwarded at byte
//               granularity, and entries drain oldest-first over a
//               valid/ready port.
// Ports       : clk      - clock
//               reset_n  - synchronous active-low reset
//               bus      - sb_coalesce_if.slave (store, load lookup, drain,
//                          flush and occupancy signals)
// Revision    : 1.0 - initial release
// ============================================================================
module sb_coalesce #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int HWM    = DEPTH - 2
) (
    input  wire logic    clk,
    input  wire logic    reset_n,
    sb_coalesce_if.slave bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_WA_W  = ADDR_W - 2;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_HWM_CNT   = c_CNT_W'(HWM);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

    // Byte mask of an access at lane 0. Size 3 yields no bytes.
    function automatic logic [3:0] f_size_mask(input logic [1:0] size);
        case (size)
            2'd0:    f_size_mask = 4'b0001;
            2'd1:    f_size_mask = 4'b0011;
            2'd2:    f_size_mask = 4'b1111;
            default: f_size_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] f_lane_expand(input logic [3:0] be);
        f_lane_expand = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // ------------------------------------------------------------------
    // Entry storage and control state
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]   r_valid;
    logic [c_WA_W-1:0]  r_waddr [DEPTH];
    logic [31:0]        r_data  [DEPTH];
    logic [3:0]         r_be    [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic               r_drain_valid;
    logic [ADDR_W-1:0]  r_drain_addr;
    logic [31:0]        r_drain_data;
    logic [3:0]         r_drain_be;
    logic               r_flush_busy;
    logic               r_misalign;
    logic               r_ld_hit;
    logic               r_ld_partial;
    logic [31:0]        r_ld_data;

    // ------------------------------------------------------------------
    // Store decode
    // ------------------------------------------------------------------
    logic [c_WA_W-1:0]  w_st_waddr;
    logic [3:0]         w_st_mask;
    logic [31:0]        w_st_lanes;
    logic [31:0]        w_st_bmask;
    logic               w_misalign;

    assign w_st_waddr = bus.st_addr[ADDR_W-1:2];
    assign w_st_mask  = f_size_mask(bus.st_size) << bus.st_addr[1:0];
    assign w_st_lanes = bus.st_data << {bus.st_addr[1:0], 3'b000};
    assign w_st_bmask = f_lane_expand(w_st_mask);

    always_comb begin
        case (bus.st_size)
            2'd0:    w_misalign = 1'b0;
            2'd1:    w_misalign = bus.st_addr[0];
            2'd2:    w_misalign = |bus.st_addr[1:0];
            default: w_misalign = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Coalesce target search. Entries are scanned oldest to youngest so
    // the last match wins, giving the youngest entry. The entry already
    // presented on the drain port is frozen and never a merge target.
    // ------------------------------------------------------------------
    logic               w_coal_found;
    logic [c_PTR_W-1:0] w_coal_idx;
    logic [c_PTR_W-1:0] w_scan_idx;

    always_comb begin
        w_coal_found = 1'b0;
        w_coal_idx   = '0;
        w_scan_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_scan_idx = r_tail + c_PTR_W'(k);
            if (r_valid[w_scan_idx] && (r_waddr[w_scan_idx] == w_st_waddr) &&
                !(r_drain_valid && (w_scan_idx == r_tail))) begin
                w_coal_found = 1'b1;
                w_coal_idx   = w_scan_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshakes and occupancy
    // ------------------------------------------------------------------
    logic        w_full;
    logic        w_empty;
    logic        w_st_ready;
    logic        w_st_acc;
    logic        w_st_write;
    logic        w_coal;
    logic        w_alloc;
    logic        w_drain_fire;
    logic        w_arm;
    logic        w_tail_merge;
    logic [31:0] w_tail_data;
    logic [3:0]  w_tail_be;

    assign w_full       = (r_count == c_DEPTH_CNT);
    assign w_empty      = (r_count == '0);
    assign w_st_ready   = !r_flush_busy && (!w_full || w_coal_found);
    assign w_st_acc     = bus.st_valid && w_st_ready;
    assign w_st_write   = w_st_acc && !w_misalign;
    assign w_coal       = w_st_write && w_coal_found;
    assign w_alloc      = w_st_write && !w_coal_found;
    assign w_drain_fire = r_drain_valid && bus.drain_ready;
    assign w_arm        = !r_drain_valid && !w_empty &&
                          (r_flush_busy || (r_count >= c_HWM_CNT) ||
                           (!bus.st_valid && !bus.ld_valid));

    // A store may merge into the tail entry on the very edge that arms the
    // drain; the drain register captures the merged value so that byte is
    // not lost when the entry is released.
    assign w_tail_merge = w_coal && (w_coal_idx == r_tail);
    assign w_tail_data  = w_tail_merge ?
                          ((r_data[r_tail] & ~w_st_bmask) | (w_st_lanes & w_st_bmask)) :
                          r_data[r_tail];
    assign w_tail_be    = w_tail_merge ? (r_be[r_tail] | w_st_mask) : r_be[r_tail];

    // ------------------------------------------------------------------
    // Load forwarding: per byte, the youngest valid entry holding it wins.
    // ------------------------------------------------------------------
    logic [c_WA_W-1:0]  w_ld_waddr;
    logic [3:0]         w_ld_mask;
    logic [3:0]         w_fwd_found;
    logic [31:0]        w_fwd_word;
    logic [c_PTR_W-1:0] w_fwd_idx;
    logic               w_ld_hit;
    logic               w_ld_partial;
    logic [31:0]        w_ld_value;

    assign w_ld_waddr = bus.ld_addr[ADDR_W-1:2];
    assign w_ld_mask  = f_size_mask(bus.ld_size) << bus.ld_addr[1:0];

    always_comb begin
        w_fwd_found = '0;
        w_fwd_word  = '0;
        w_fwd_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_fwd_idx = r_tail + c_PTR_W'(k);
            if (r_valid[w_fwd_idx] && (r_waddr[w_fwd_idx] == w_ld_waddr)) begin
                for (int b = 0; b < 4; b++) begin
                    if (r_be[w_fwd_idx][b] && w_ld_mask[b]) begin
                        w_fwd_found[b]       = 1'b1;
                        w_fwd_word[8*b +: 8] = r_data[w_fwd_idx][8*b +: 8];
                    end
                end
            end
        end
    end

    assign w_ld_hit     = (w_ld_mask != 4'b0000) && (w_fwd_found == w_ld_mask);
    assign w_ld_partial = (w_fwd_found != 4'b0000) && (w_fwd_found != w_ld_mask);
    // Only requested bytes were gathered, so the shift zero-extends.
    assign w_ld_value   = w_fwd_word >> {bus.ld_addr[1:0], 3'b000};

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_waddr[i] <= '0;
                r_data[i]  <= '0;
                r_be[i]    <= '0;
            end
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_drain_valid <= 1'b0;
            r_drain_addr  <= '0;
            r_drain_data  <= '0;
            r_drain_be    <= '0;
            r_flush_busy  <= 1'b0;
            r_misalign    <= 1'b0;
            r_ld_hit      <= 1'b0;
            r_ld_partial  <= 1'b0;
            r_ld_data     <= '0;
        end else begin
            r_ld_hit     <= bus.ld_valid && w_ld_hit;
            r_ld_partial <= bus.ld_valid && w_ld_partial;
            r_ld_data    <= (bus.ld_valid && w_ld_hit) ? w_ld_value : 32'h0;
            r_misalign   <= w_st_acc && w_misalign;

            if (w_coal) begin
                r_data[w_coal_idx] <= (r_data[w_coal_idx] & ~w_st_bmask) |
                                      (w_st_lanes & w_st_bmask);
                r_be[w_coal_idx]   <= r_be[w_coal_idx] | w_st_mask;
            end

            // Allocation at head never collides with the drain at tail:
            // head == tail only when the buffer is empty or full.
            if (w_alloc) begin
                r_valid[r_head] <= 1'b1;
                r_waddr[r_head] <= w_st_waddr;
                r_data[r_head]  <= w_st_lanes & w_st_bmask;
                r_be[r_head]    <= w_st_mask;
                r_head          <= r_head + c_PTR_ONE;
            end

            if (w_drain_fire) begin
                r_valid[r_tail] <= 1'b0;
                r_tail          <= r_tail + c_PTR_ONE;
                r_drain_valid   <= 1'b0;
            end else if (w_arm) begin
                r_drain_valid <= 1'b1;
                r_drain_addr  <= {r_waddr[r_tail], 2'b00};
                r_drain_data  <= w_tail_data;
                r_drain_be    <= w_tail_be;
            end

            case ({w_alloc, w_drain_fire})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            // A flush that coincides with the first allocation into an
            // empty buffer still has work to do, so it must latch.
            if (bus.flush && (!w_empty || w_alloc)) begin
                r_flush_busy <= 1'b1;
            end else if (w_empty && !r_drain_valid) begin
                r_flush_busy <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.st_ready    = w_st_ready;
    assign bus.st_misalign = r_misalign;
    assign bus.ld_hit      = r_ld_hit;
    assign bus.ld_partial  = r_ld_partial;
    assign bus.ld_data     = r_ld_data;
    assign bus.drain_valid = r_drain_valid;
    assign bus.drain_addr  = r_drain_addr;
    assign bus.drain_data  = r_drain_data;
    assign bus.drain_be    = r_drain_be;
    assign bus.flush_busy  = r_flush_busy;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sb_coalesce.sv
`default_nettype none
// ============================================================================
// Module      : tb_sb_coalesce
// Description : Self-checking bench for sb_coalesce. A queue-based reference
//               model (oldest entry at index 0) predicts every output each
//               cycle; directed sequences plus randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sb_coalesce;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 32;
    localparam int HWM    = DEPTH - 2;

    logic clk;
    logic reset_n;

    sb_coalesce_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    sb_coalesce #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HWM(HWM)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;
    logic last_rdy;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [29:0] wa;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    ent_t        q[$];
    logic        m_dv, m_fb, m_mis, m_hit, m_part;
    logic [31:0] m_da, m_dd, m_ld;
    logic [3:0]  m_db;

    task automatic model_reset();
        q.delete();
        m_dv = 0; m_fb = 0; m_mis = 0; m_hit = 0; m_part = 0;
        m_da = 0; m_dd = 0; m_ld = 0; m_db = 0;
    endtask

    task automatic model_step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                              input logic [1:0] ss, input logic lv, input logic [31:0] la,
                              input logic [1:0] ls, input logic dr, input logic fl,
                              output logic rdy);
        int n_pre, nb, want, tgt, found, lane;
        logic mis, acc, alloc, arm, fire, dv_pre, got;
        logic [31:0] fwd;
        ent_t e;
        n_pre  = q.size();
        dv_pre = m_dv;
        nb  = (ss == 2'd0) ? 1 : (ss == 2'd1) ? 2 : 4;
        mis = (ss == 2'd3) || ((int'(sa[1:0]) % nb) != 0);
        tgt = -1;
        for (int i = n_pre - 1; i >= (dv_pre ? 1 : 0); i--)
            if (tgt < 0 && q[i].wa == sa[31:2]) tgt = i;
        rdy = !m_fb && (n_pre < DEPTH || tgt >= 0);
        acc = sv && rdy;

        want  = (ls == 2'd0) ? 1 : (ls == 2'd1) ? 2 : 4;
        found = 0;
        fwd   = 0;
        for (int j = 0; j < want; j++) begin
            lane = int'(la[1:0]) + j;
            got  = 0;
            for (int i = n_pre - 1; i >= 0; i--) begin
                e = q[i];
                if (!got && e.wa == la[31:2] && e.be[lane]) begin
                    fwd   = fwd | (((e.data >> (8 * lane)) & 32'hFF) << (8 * j));
                    got   = 1;
                    found++;
                end
            end
        end
        m_hit  = lv && (found == want);
        m_part = lv && (found > 0) && (found < want);
        m_ld   = (lv && found == want) ? fwd : 32'h0;
        m_mis  = acc && mis;

        arm   = !dv_pre && (n_pre > 0) && (m_fb || n_pre >= HWM || (!sv && !lv));
        fire  = dv_pre && dr;
        alloc = 0;
        if (acc && !mis) begin
            if (tgt >= 0) e = q[tgt];
            else begin e.wa = sa[31:2]; e.data = 0; e.be = 0; end
            for (int b = 0; b < nb; b++) begin
                lane = int'(sa[1:0]) + b;
                e.data[8*lane +: 8] = sd[8*b +: 8];
                e.be[lane] = 1'b1;
            end
            if (tgt >= 0) q[tgt] = e;
            else begin q.push_back(e); alloc = 1; end
        end
        if (fl && (n_pre > 0 || alloc)) m_fb = 1;
        else if (n_pre == 0 && !dv_pre) m_fb = 0;
        if (fire) begin
            void'(q.pop_front());
            m_dv = 0;
        end else if (arm) begin
            m_dv = 1;
            m_da = {q[0].wa, 2'b00};
            m_dd = q[0].data;
            m_db = q[0].be;
        end
    endtask

    task automatic compare_all();
        check("st_misalign", bus.st_misalign, m_mis);
        check("ld_hit",      bus.ld_hit,      m_hit);
        check("ld_partial",  bus.ld_partial,  m_part);
        check("ld_data",     bus.ld_data,     m_ld);
        check("drain_valid", bus.drain_valid, m_dv);
        check("drain_addr",  bus.drain_addr,  m_da);
        check("drain_data",  bus.drain_data,  m_dd);
        check("drain_be",    bus.drain_be,    m_db);
        check("flush_busy",  bus.flush_busy,  m_fb);
        check("full",        bus.full,        q.size() == DEPTH);
        check("empty",       bus.empty,       q.size() == 0);
        check("count",       bus.count,       q.size());
    endtask

    // One clock: drive at the falling edge, check st_ready, let the rising
    // edge commit, then compare every output at the next falling edge.
    task automatic cycle(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic [1:0] ss, input logic lv, input logic [31:0] la,
                         input logic [1:0] ls, input logic dr, input logic fl);
        logic exp_rdy;
        bus.st_valid = sv; bus.st_addr = sa; bus.st_data = sd; bus.st_size = ss;
        bus.ld_valid = lv; bus.ld_addr = la; bus.ld_size = ls;
        bus.drain_ready = dr; bus.flush = fl;
        #1;
        model_step(sv, sa, sd, ss, lv, la, ls, dr, fl, exp_rdy);
        last_rdy = bus.st_ready;
        check("st_ready", bus.st_ready, exp_rdy);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input logic dr);
        cycle(0, 0, 0, 0, 0, 0, 0, dr, 0);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s, input logic dr);
        cycle(1, a, d, s, 0, 0, 0, dr, 0);
    endtask

    task automatic ld(input logic [31:0] a, input logic [1:0] s);
        cycle(0, 0, 0, 0, 1, a, s, 0, 0);
    endtask

    task automatic do_reset();
        reset_n = 0;
        bus.st_valid = 0; bus.st_addr = 0; bus.st_data = 0; bus.st_size = 0;
        bus.ld_valid = 0; bus.ld_addr = 0; bus.ld_size = 0;
        bus.drain_ready = 0; bus.flush = 0;
        @(negedge clk);
        reset_n = 1;
        model_reset();
        compare_all();
    endtask

    task automatic drain_all();
        for (int i = 0; i < 64 && !(bus.empty && !bus.drain_valid); i++) idle(1);
        check("drain_all_empty", bus.empty, 1);
        check("drain_all_idle", bus.drain_valid, 0);
    endtask

    task automatic rand_cycle(input int p_st, input int p_ld, input int p_dr, input int p_fl);
        logic sv, lv, dr, fl;
        logic [31:0] sa, sd, la;
        logic [1:0] ss, ls;
        sv = ($urandom_range(0, 99) < 32'(p_st));
        lv = ($urandom_range(0, 99) < 32'(p_ld));
        dr = ($urandom_range(0, 99) < 32'(p_dr));
        fl = ($urandom_range(0, 99) < 32'(p_fl));
        ss = 2'($urandom_range(0, 2));
        sa = 32'h100 + 32'(4 * $urandom_range(0, 11));
        if (ss == 2'd0) sa[1:0] = 2'($urandom_range(0, 3));
        if (ss == 2'd1) sa[1:0] = 2'(2 * $urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) begin
            ss = 2'($urandom_range(0, 3));
            sa[1:0] = 2'($urandom_range(0, 3));
        end
        sd = $urandom;
        ls = 2'($urandom_range(0, 2));
        la = 32'h100 + 32'(4 * $urandom_range(0, 11));
        if (ls == 2'd0) la[1:0] = 2'($urandom_range(0, 3));
        if (ls == 2'd1) la[1:0] = 2'(2 * $urandom_range(0, 1));
        cycle(sv, sa, sd, ss, lv, la, ls, dr, fl);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_rdy = 0;
        do_reset();

        // Single word store drains when idle
        st(32'h100, 32'hDEADBEEF, 2, 0);
        idle(0);
        check("tp1_dv",   bus.drain_valid, 1);
        check("tp1_addr", bus.drain_addr,  32'h100);
        check("tp1_data", bus.drain_data,  32'hDEADBEEF);
        check("tp1_be",   bus.drain_be,    4'hF);
        idle(1);
        check("tp1_empty", bus.empty, 1);

        // Byte and half merge into one entry
        st(32'h201, 32'h000000AA, 0, 0);
        st(32'h202, 32'h00001234, 1, 0);
        check("tp2_count", bus.count, 1);
        idle(0);
        check("tp2_be",   bus.drain_be,   4'hE);
        check("tp2_data", bus.drain_data, 32'h1234AA00);
        drain_all();

        // Forwarding hit, miss and partial
        st(32'h300, 32'h11223344, 2, 0);
        ld(32'h302, 0);
        check("tp3_hit",  bus.ld_hit,  1);
        check("tp3_data", bus.ld_data, 32'h22);
        ld(32'h305, 0);
        check("tp3_miss_hit",  bus.ld_hit,     0);
        check("tp3_miss_part", bus.ld_partial, 0);
        drain_all();
        st(32'h400, 32'h00005566, 1, 0);
        ld(32'h400, 2);
        check("tp3_partial",      bus.ld_partial, 1);
        check("tp3_partial_data", bus.ld_data,    32'h0);
        drain_all();

        // Fill to full, then coalesce into a non-tail word
        for (int i = 0; i < DEPTH; i++) st(32'h500 + 32'(4 * i), $urandom, 2, 0);
        check("tp4_full", bus.full, 1);
        st(32'h600, 32'hCAFEF00D, 2, 0);
        check("tp4_rdy_new", last_rdy, 0);
        st(32'h50C, 32'h0BADCAFE, 2, 0);
        check("tp4_rdy_merge", last_rdy, 1);
        drain_all();

        // Misaligned store and flush
        st(32'h101, 32'h00001234, 1, 0);
        check("tp5_mis",   bus.st_misalign, 1);
        check("tp5_count", bus.count, 0);
        for (int i = 0; i < 3; i++) st(32'h700 + 32'(4 * i), $urandom, 2, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("tp5_busy", bus.flush_busy, 1);
        for (int i = 0; i < 40 && bus.flush_busy; i++) begin
            st(32'h800, 32'h12345678, 2, 1);
            check("tp5_rdy_busy", last_rdy, 0);
        end
        check("tp5_busy_done", bus.flush_busy, 0);
        drain_all();

        // Reset while a drain is presented
        for (int i = 0; i < 4; i++) st(32'h900 + 32'(4 * i), $urandom, 2, 0);
        idle(0);
        check("tp6_dv", bus.drain_valid, 1);
        do_reset();
        check("tp6_dv_after",    bus.drain_valid, 0);
        check("tp6_count_after", bus.count, 0);
        check("tp6_empty_after", bus.empty, 1);

        // Randomized traffic
        for (int i = 0; i < 150; i++) rand_cycle(60, 40, 0, 0);
        for (int i = 0; i < 600; i++) rand_cycle(60, 40, 30, 2);
        for (int i = 0; i < 600; i++) rand_cycle(50, 50, 90, 3);
        for (int i = 0; i < 600; i++) rand_cycle(80, 30, 50, 1);
        for (int i = 0; i < 400; i++) rand_cycle(20, 60, 70, 5);
        drain_all();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
